// File: rtl/eth_phy_10g_rx_link_ctrl.sv
// 10GBASE-R RX link sequencer: SERDES reset pulsing, lock/BER qualification, link-down counter.
// Latency: all outputs registered, reflecting the state entered on each rx_clk edge; no backpressure.
module eth_phy_10g_rx_link_ctrl #(
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int RESET_CYCLES  = 16,
  parameter int GOOD_CYCLES   = 125,
  parameter int HIBER_TIMEOUT = 4096,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                 rx_clk,
  input  logic                 rx_rst,
  input  logic                 rx_block_lock,
  input  logic                 rx_high_ber,
  input  logic                 cfg_enable,
  input  logic                 cfg_restart,
  input  logic                 link_down_count_clr,
  output logic                 serdes_rx_reset_req,
  output logic                 rx_status,
  output logic [1:0]           link_state,
  output logic [CNT_WIDTH-1:0] link_down_count
);

  localparam int TMAX = (LOCK_TIMEOUT > RESET_CYCLES) ? LOCK_TIMEOUT : RESET_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int GW   = (GOOD_CYCLES > 1) ? $clog2(GOOD_CYCLES) : 1;
  localparam int HW   = (HIBER_TIMEOUT > 1) ? $clog2(HIBER_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_WAIT_GOOD = 2'd2,
    ST_UP        = 2'd3
  } state_t;

  state_t               state, state_n;
  logic [TW-1:0]        state_timer, timer_n;
  logic [GW-1:0]        good_cnt, good_n;
  logic [HW-1:0]        hiber_cnt, hiber_n;
  logic                 req_n;
  logic                 good;
  logic                 leave_up;
  logic [CNT_WIDTH-1:0] cnt_n;

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      state               <= ST_RESET;
      state_timer         <= '0;
      good_cnt            <= '0;
      hiber_cnt           <= '0;
      serdes_rx_reset_req <= 1'b0;
      rx_status           <= 1'b0;
      link_down_count     <= '0;
    end else begin
      state               <= state_n;
      state_timer         <= timer_n;
      good_cnt            <= good_n;
      hiber_cnt           <= hiber_n;
      serdes_rx_reset_req <= req_n;
      rx_status           <= (state_n == ST_UP);
      link_down_count     <= cnt_n;
    end
  end

  assign link_state = state;

  always_comb begin
    state_n  = state;
    timer_n  = state_timer + 1'b1;
    good_n   = good_cnt;
    hiber_n  = hiber_cnt;
    req_n    = 1'b0;
    good     = rx_block_lock && !rx_high_ber;
    leave_up = 1'b0;
    cnt_n    = link_down_count;

    if (!cfg_enable) begin
      state_n = ST_RESET;
      timer_n = '0;
    end else if (cfg_restart) begin
      state_n = ST_RESET;
      timer_n = '0;
    end else begin
      unique case (state)
        ST_RESET: begin
          // Entry via enable/restart/rx_rst arrives with req low: raise it first, then time it.
          if (!serdes_rx_reset_req) begin
            req_n   = 1'b1;
            timer_n = '0;
          end else if (state_timer == TW'(RESET_CYCLES - 1)) begin
            state_n = ST_WAIT_LOCK;
          end else begin
            req_n = 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (rx_block_lock) begin
            state_n = ST_WAIT_GOOD;
            good_n  = '0;
            hiber_n = '0;
          end else if (state_timer == TW'(LOCK_TIMEOUT - 1)) begin
            state_n = ST_RESET;
            req_n   = 1'b1;
          end
        end
        default: begin
          hiber_n = rx_high_ber ? hiber_cnt + 1'b1 : '0;
          if (rx_high_ber && hiber_cnt == HW'(HIBER_TIMEOUT - 1)) begin
            state_n = ST_RESET;
            req_n   = 1'b1;
          end else if (!rx_block_lock) begin
            state_n = ST_WAIT_LOCK;
          end else if (state == ST_UP) begin
            if (rx_high_ber) begin
              state_n = ST_WAIT_GOOD;
              good_n  = '0;
            end
          end else if (good) begin
            good_n = good_cnt + 1'b1;
            if (good_cnt == GW'(GOOD_CYCLES - 1)) state_n = ST_UP;
          end else begin
            good_n = '0;
          end
        end
      endcase
    end

    if (state_n != state) timer_n = '0;
    if (state_n == ST_RESET || state_n == ST_WAIT_LOCK) hiber_n = '0;

    leave_up = (state == ST_UP) && (state_n != ST_UP);
    if (link_down_count_clr) begin
      cnt_n = leave_up ? CNT_WIDTH'(1) : '0;
    end else if (leave_up && !(&link_down_count)) begin
      cnt_n = link_down_count + 1'b1;
    end
  end

endmodule
